// File: rtl/axi_addr_translator_pkg.sv
// Shared AXI address-channel field widths, request layout and FSM encoding for the MMU translator.
package axi_addr_translator_pkg;

  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int PROT_W  = 3;
  localparam int CACHE_W = 4;
  localparam int USER_W  = 2;
  localparam int CNT_W   = 16;

  // Field order matches the RX buffer word, MSB first.
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
    logic [PROT_W-1:0]  prot;
    logic [CACHE_W-1:0] cache;
    logic [USER_W-1:0]  user;
    logic               lock;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_SEND   = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  // Total burst span in bytes; 33 bits holds the worst case with margin.
  function automatic logic [32:0] burst_bytes(input logic [LEN_W-1:0] len,
                                              input logic [SIZE_W-1:0] size);
    return ({25'd0, len} + 33'd1) << size;
  endfunction

endpackage

// File: rtl/axi_addr_translator_if.sv
// Address-channel bundle: RX buffer head/pop on one side, translated request valid/ready on the other.
interface axi_addr_translator_if;
  import axi_addr_translator_pkg::*;

  logic               in_avail;
  logic [ID_W-1:0]    in_id;
  logic [ADDR_W-1:0]  in_addr;
  logic [LEN_W-1:0]   in_len;
  logic [SIZE_W-1:0]  in_size;
  logic [BURST_W-1:0] in_burst;
  logic [PROT_W-1:0]  in_prot;
  logic [CACHE_W-1:0] in_cache;
  logic [USER_W-1:0]  in_user;
  logic               in_lock;
  logic               o_buf_rd;

  logic               m_valid;
  logic               m_ready;
  logic [ID_W-1:0]    m_id;
  logic [ADDR_W-1:0]  m_addr;
  logic [LEN_W-1:0]   m_len;
  logic [SIZE_W-1:0]  m_size;
  logic [BURST_W-1:0] m_burst;
  logic [PROT_W-1:0]  m_prot;
  logic [CACHE_W-1:0] m_cache;
  logic [USER_W-1:0]  m_user;
  logic               m_lock;

  // Translator side: consumes the buffer head, drives the memory request.
  modport master (
    input  in_avail, in_id, in_addr, in_len, in_size, in_burst, in_prot, in_cache, in_user, in_lock,
    output o_buf_rd,
    output m_valid, m_id, m_addr, m_len, m_size, m_burst, m_prot, m_cache, m_user, m_lock,
    input  m_ready
  );

  // Environment side: RX buffer plus memory-side acceptor.
  modport slave (
    output in_avail, in_id, in_addr, in_len, in_size, in_burst, in_prot, in_cache, in_user, in_lock,
    input  o_buf_rd,
    input  m_valid, m_id, m_addr, m_len, m_size, m_burst, m_prot, m_cache, m_user, m_lock,
    output m_ready
  );

endinterface

// File: rtl/axi_seg_lookup.sv
// Combinational segment comparator: finds the lowest-index entry fully containing the burst and rebases it.
module axi_seg_lookup
  import axi_addr_translator_pkg::*;
#(
  parameter int NUM_SEG = 4,
  parameter int IDX_W   = 2
) (
  input  logic [ADDR_W-1:0]               addr,
  input  logic [LEN_W-1:0]                len,
  input  logic [SIZE_W-1:0]               size,
  input  logic [NUM_SEG-1:0][ADDR_W-1:0]  va_base,
  input  logic [NUM_SEG-1:0][ADDR_W-1:0]  limit,
  input  logic [NUM_SEG-1:0][ADDR_W-1:0]  pa_base,
  output logic                            hit,
  output logic [IDX_W-1:0]                idx,
  output logic [ADDR_W-1:0]               xlat_addr
);

  logic [32:0] bytes;
  logic [32:0] off;
  logic [33:0] span;

  assign bytes = burst_bytes(len, size);

  // Scan high to low so the lowest matching index is the last one written.
  always_comb begin
    hit       = 1'b0;
    idx       = '0;
    xlat_addr = '0;
    off       = '0;
    span      = '0;
    for (int i = NUM_SEG - 1; i >= 0; i--) begin
      off  = {1'b0, addr} - {1'b0, va_base[i]};
      span = {2'b00, off[31:0]} + {1'b0, bytes};
      if ((limit[i] != '0) && !off[32] && (span <= {2'b00, limit[i]})) begin
        hit       = 1'b1;
        idx       = IDX_W'(i);
        xlat_addr = pa_base[i] + off[31:0];
      end
    end
  end

endmodule

// File: rtl/axi_addr_translator.sv
// Pops one buffered AR/AW request at a time, checks it against the segment table, then forwards or faults.
// Pop to m_valid is 2 cycles; m_* hold until m_ready, and no new pop is issued while a request is pending.
module axi_addr_translator
  import axi_addr_translator_pkg::*;
#(
  parameter int NUM_SEG = 4,
  parameter int IDX_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic                  rx_clk,
  input  logic                  reset,
  axi_addr_translator_if.master bus,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_W-1:0]     cfg_va_base,
  input  logic [ADDR_W-1:0]     cfg_limit,
  input  logic [ADDR_W-1:0]     cfg_pa_base,
  output logic                  fault,
  output logic [ID_W-1:0]       fault_id,
  output logic [ADDR_W-1:0]     fault_addr,
  output logic [CNT_W-1:0]      fault_cnt
);

  state_t state, nxt;
  req_t   req, in_req, m_req;
  logic   pop, load_m, load_fault;

  logic [NUM_SEG-1:0][ADDR_W-1:0] tbl_va, tbl_lim, tbl_pa;

  logic              hit;
  logic [IDX_W-1:0]  hit_idx_unused;
  logic [ADDR_W-1:0] xlat_addr;

  assign in_req = '{id: bus.in_id, addr: bus.in_addr, len: bus.in_len, size: bus.in_size,
                    burst: bus.in_burst, prot: bus.in_prot, cache: bus.in_cache,
                    user: bus.in_user, lock: bus.in_lock};

  axi_seg_lookup #(.NUM_SEG(NUM_SEG), .IDX_W(IDX_W)) u_lookup (
    .addr      (req.addr),
    .len       (req.len),
    .size      (req.size),
    .va_base   (tbl_va),
    .limit     (tbl_lim),
    .pa_base   (tbl_pa),
    .hit       (hit),
    .idx       (hit_idx_unused),
    .xlat_addr (xlat_addr)
  );

  // Registered table: a same-cycle write during LOOKUP is seen only by later lookups.
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      tbl_va  <= '0;
      tbl_lim <= '0;
      tbl_pa  <= '0;
    end else begin
      for (int i = 0; i < NUM_SEG; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          tbl_va[i]  <= cfg_va_base;
          tbl_lim[i] <= cfg_limit;
          tbl_pa[i]  <= cfg_pa_base;
        end
      end
    end
  end

  always_ff @(posedge rx_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt        = state;
    pop        = 1'b0;
    load_m     = 1'b0;
    load_fault = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.in_avail) begin
          pop = 1'b1;
          nxt = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          load_m = 1'b1;
          nxt    = ST_SEND;
        end else begin
          load_fault = 1'b1;
          nxt        = ST_FAULT;
        end
      end
      ST_SEND:  if (bus.m_ready) nxt = ST_IDLE;
      ST_FAULT: nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // The upstream buffer is reset alongside us, so never pop during reset.
  assign bus.o_buf_rd = pop & ~reset;
  assign bus.m_valid  = (state == ST_SEND);
  assign fault        = (state == ST_FAULT);

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      req        <= '0;
      m_req      <= '0;
      fault_id   <= '0;
      fault_addr <= '0;
      fault_cnt  <= '0;
    end else begin
      if (pop) req <= in_req;
      if (load_m) begin
        m_req      <= req;
        m_req.addr <= xlat_addr;
      end
      // Fault record lands on entry to FAULT so it is valid alongside the pulse.
      if (load_fault) begin
        fault_id   <= req.id;
        fault_addr <= req.addr;
        if (fault_cnt != {CNT_W{1'b1}}) fault_cnt <= fault_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.m_id    = m_req.id;
  assign bus.m_addr  = m_req.addr;
  assign bus.m_len   = m_req.len;
  assign bus.m_size  = m_req.size;
  assign bus.m_burst = m_req.burst;
  assign bus.m_prot  = m_req.prot;
  assign bus.m_cache = m_req.cache;
  assign bus.m_user  = m_req.user;
  assign bus.m_lock  = m_req.lock;

endmodule

// File: tb/tb_axi_addr_translator.sv
// Directed bench: models the RX buffer as a queue and checks translation, faults, stalls and reset.
module tb_axi_addr_translator;
  import axi_addr_translator_pkg::*;

  logic        rx_clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_va_base, cfg_limit, cfg_pa_base;
  logic        fault;
  logic [3:0]  fault_id;
  logic [31:0] fault_addr;
  logic [15:0] fault_cnt;

  axi_addr_translator_if bus ();

  axi_addr_translator #(.NUM_SEG(4), .IDX_W(2)) dut (
    .rx_clk      (rx_clk),
    .reset       (reset),
    .bus         (bus),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_va_base (cfg_va_base),
    .cfg_limit   (cfg_limit),
    .cfg_pa_base (cfg_pa_base),
    .fault       (fault),
    .fault_id    (fault_id),
    .fault_addr  (fault_addr),
    .fault_cnt   (fault_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } pkt_t;

  pkt_t q[$];
  int   cyc = 0, pop_cyc = 0, npop = 0, n_hs = 0;
  int   n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_head();
    if (q.size() > 0) begin
      bus.in_avail = 1'b1;
      bus.in_id    = q[0].id;
      bus.in_addr  = q[0].addr;
      bus.in_len   = q[0].len;
      bus.in_size  = q[0].size;
    end else begin
      bus.in_avail = 1'b0;
      bus.in_id    = '0;
      bus.in_addr  = '0;
      bus.in_len   = '0;
      bus.in_size  = '0;
    end
    bus.in_burst = 2'b01;
    bus.in_prot  = 3'd2;
    bus.in_cache = 4'd3;
    bus.in_user  = 2'd2;
    bus.in_lock  = 1'b1;
  endtask

  // RX buffer model: pops on the sampled strobe, presents the new head just after the edge.
  initial begin
    drive_head();
    forever begin
      @(posedge rx_clk);
      if (bus.o_buf_rd) begin
        pop_cyc = cyc;
        npop++;
        if (q.size() > 0) q.delete(0);
      end
      if (bus.m_valid && bus.m_ready) n_hs++;
      cyc++;
      #1;
      drive_head();
    end
  end

  task automatic push(input logic [3:0] id, input logic [31:0] addr,
                      input logic [7:0] len, input logic [2:0] size);
    pkt_t p;
    p.id = id; p.addr = addr; p.len = len; p.size = size;
    q.push_back(p);
  endtask

  task automatic cfg_wr(input logic [1:0] idx, input logic [31:0] va,
                        input logic [31:0] lim, input logic [31:0] pa);
    cfg_idx = idx; cfg_va_base = va; cfg_limit = lim; cfg_pa_base = pa;
    cfg_we = 1'b1;
    @(negedge rx_clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge rx_clk);
      if (bus.m_valid) begin ok = 1'b1; break; end
    end
    check({tag, " m_valid seen"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_fault(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge rx_clk);
      if (fault) begin ok = 1'b1; break; end
    end
    check({tag, " fault seen"}, 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, h0, c0;
    bit stable, ok;
    logic [31:0] a0;

    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0;
    cfg_va_base = '0; cfg_limit = '0; cfg_pa_base = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(negedge rx_clk);
    check("rst m_valid", 64'(bus.m_valid), 64'd0);
    check("rst o_buf_rd", 64'(bus.o_buf_rd), 64'd0);
    check("rst fault", 64'(fault), 64'd0);
    check("rst fault_cnt", 64'(fault_cnt), 64'd0);
    check("rst fault_addr", 64'(fault_addr), 64'd0);
    check("rst m_addr", 64'(bus.m_addr), 64'd0);
    reset = 1'b0;
    @(negedge rx_clk);

    // Basic hit with rebase and field passthrough
    cfg_wr(2'd0, 32'h1000_0000, 32'h0010_0000, 32'h8000_0000);
    p0 = npop;
    push(4'd5, 32'h1000_0040, 8'd3, 3'd2);
    wait_valid("t1");
    check("t1 pop-to-valid", 64'(cyc - pop_cyc), 64'd2);
    check("t1 pops", 64'(npop - p0), 64'd1);
    check("t1 m_addr", 64'(bus.m_addr), 64'h8000_0040);
    check("t1 m_id", 64'(bus.m_id), 64'd5);
    check("t1 m_len", 64'(bus.m_len), 64'd3);
    check("t1 m_size", 64'(bus.m_size), 64'd2);
    check("t1 passthru", 64'({bus.m_burst, bus.m_prot, bus.m_cache, bus.m_user, bus.m_lock}),
          64'({2'b01, 3'd2, 4'd3, 2'd2, 1'b1}));
    @(negedge rx_clk);
    check("t1 valid drops", 64'(bus.m_valid), 64'd0);

    // Burst end beyond limit faults; ending exactly at limit hits; below base faults
    h0 = n_hs;
    push(4'd6, 32'h100F_FFF0, 8'd7, 3'd2);
    wait_fault("t2a");
    check("t2a fault_addr", 64'(fault_addr), 64'h100F_FFF0);
    check("t2a fault_id", 64'(fault_id), 64'd6);
    check("t2a fault_cnt", 64'(fault_cnt), 64'd1);
    check("t2a no handshake", 64'(n_hs - h0), 64'd0);
    @(negedge rx_clk);
    check("t2a fault one cycle", 64'(fault), 64'd0);
    push(4'd7, 32'h100F_FFE0, 8'd7, 3'd2);
    wait_valid("t2b");
    check("t2b m_addr", 64'(bus.m_addr), 64'h800F_FFE0);
    push(4'd8, 32'h0FFF_FFFC, 8'd0, 3'd2);
    wait_fault("t2c");
    check("t2c below base addr", 64'(fault_addr), 64'h0FFF_FFFC);
    check("t2c fault_cnt", 64'(fault_cnt), 64'd2);

    // Overlapping entries: lowest index wins; a higher entry alone still translates
    cfg_wr(2'd1, 32'h1000_0000, 32'h0000_1000, 32'h9000_0000);
    cfg_wr(2'd2, 32'h2000_0000, 32'h0000_0100, 32'h3000_0000);
    push(4'd9, 32'h1000_0000, 8'd0, 3'd0);
    wait_valid("t3a");
    check("t3a priority m_addr", 64'(bus.m_addr), 64'h8000_0000);
    push(4'd10, 32'h2000_00F0, 8'd3, 3'd2);
    wait_valid("t3b");
    check("t3b seg2 m_addr", 64'(bus.m_addr), 64'h3000_00F0);

    // Backpressure: fields hold, no pops, then the queue drains in order
    @(negedge rx_clk);
    bus.m_ready = 1'b0;
    p0 = npop;
    for (int k = 1; k <= 4; k++) push(4'(k), 32'h1000_0000 + 32'(k) * 32'h100, 8'd1, 3'd3);
    wait_valid("t4 first");
    a0 = bus.m_addr;
    check("t4 first m_addr", 64'(a0), 64'h8000_0100);
    stable = 1'b1;
    repeat (5) begin
      @(negedge rx_clk);
      if (!bus.m_valid || bus.m_addr !== a0 || bus.m_id !== 4'd1 || bus.m_len !== 8'd1) stable = 1'b0;
    end
    check("t4 stall stable", 64'(stable), 64'd1);
    check("t4 no pop in stall", 64'(npop - p0), 64'd1);
    bus.m_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      wait_valid("t4 drain");
      check("t4 drain m_addr", 64'(bus.m_addr), 64'h8000_0000 + 64'(k) * 64'h100);
      check("t4 drain m_id", 64'(bus.m_id), 64'(k));
    end
    check("t4 total pops", 64'(npop - p0), 64'd4);

    // Table write landing in the LOOKUP cycle uses the old entry
    @(negedge rx_clk);
    push(4'd11, 32'h1000_0040, 8'd0, 3'd2);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge rx_clk);
      if (bus.o_buf_rd) begin ok = 1'b1; break; end
    end
    check("t5 pop seen", 64'(ok), 64'd1);
    @(negedge rx_clk);
    check("t5 lookup cycle", 64'(bus.m_valid), 64'd0);
    cfg_idx = 2'd0; cfg_va_base = 32'h1000_0000; cfg_limit = 32'h0010_0000;
    cfg_pa_base = 32'hA000_0000; cfg_we = 1'b1;
    @(negedge rx_clk);
    cfg_we = 1'b0;
    check("t5 send valid", 64'(bus.m_valid), 64'd1);
    check("t5 old pa", 64'(bus.m_addr), 64'h8000_0040);
    push(4'd12, 32'h1000_0040, 8'd0, 3'd2);
    wait_valid("t5 next");
    check("t5 new pa", 64'(bus.m_addr), 64'hA000_0040);

    // Reset while SEND is stalled
    @(negedge rx_clk);
    bus.m_ready = 1'b0;
    push(4'd13, 32'h1000_0080, 8'd0, 3'd2);
    wait_valid("t6");
    h0 = n_hs;
    c0 = npop;
    reset = 1'b1;
    @(negedge rx_clk);
    check("t6 m_valid", 64'(bus.m_valid), 64'd0);
    check("t6 fault_cnt", 64'(fault_cnt), 64'd0);
    check("t6 m_addr", 64'(bus.m_addr), 64'd0);
    reset = 1'b0;
    bus.m_ready = 1'b1;
    push(4'd14, 32'h1000_0080, 8'd0, 3'd2);
    wait_fault("t6 post");
    check("t6 post fault_cnt", 64'(fault_cnt), 64'd1);
    check("t6 post fault_id", 64'(fault_id), 64'd14);
    check("t6 post fault_addr", 64'(fault_addr), 64'h1000_0080);
    check("t6 no handshake", 64'(n_hs - h0), 64'd0);
    check("t6 single pop", 64'(npop - c0), 64'd1);

    repeat (2) @(negedge rx_clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
